// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32I pipeline datapath and its central
// stall/flush/forward controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
) ();

    // Register specifiers and status from the ID/EX/MEM/WB stages
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic             dmem_req;
    logic             dmem_ready;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;

    // Pipeline register controls and forwarding selects
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    // Status and performance counters
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_rd, mem_reg_write, dmem_req,
               dmem_ready, wb_rd, wb_reg_write,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b,
               mem_timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_rd, mem_reg_write, dmem_req,
               dmem_ready, wb_rd, wb_reg_write,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b,
               mem_timeout_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage RV32I pipeline,
// with a data-memory wait FSM (timeout protected) and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // EX/MEM result is younger than MEM/WB, so it wins; x0 is hardwired zero.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        logic [1:0] sel;
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = 2'b10;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1'b1);
        end
        return r;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              wait_clr_s;
    logic              wait_inc_s;
    logic              timeout_s;
    logic              mem_stall_s;
    logic              load_use_s;
    logic              stall_evt_s;
    logic              flush_evt_s;
    logic              err_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic              pc_en_s;
    logic              ifid_en_s;
    logic              idex_en_s;
    logic              exmem_en_s;
    logic              memwb_en_s;
    logic              ifid_flush_s;
    logic              idex_flush_s;
    logic              memwb_flush_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;

    assign load_use_s = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                        ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

    // Memory-wait FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Consecutive wait-cycle counter used for the forced-release timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (wait_clr_s) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (wait_inc_s) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // FSM next state; the release cycle itself is not a stall cycle
    always_comb begin
        state_nxt_s = state_r;
        wait_clr_s  = 1'b0;
        wait_inc_s  = 1'b0;
        timeout_s   = 1'b0;
        mem_stall_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (hz.dmem_req && !hz.dmem_ready) begin
                    mem_stall_s = 1'b1;
                    wait_clr_s  = 1'b1;
                    state_nxt_s = ST_MEM_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_nxt_s = ST_RUN;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    mem_stall_s = 1'b1;
                    wait_inc_s  = 1'b1;
                    state_nxt_s = ST_MEM_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Stall/flush arbitration: memory stall > branch flush > load-use > run
    always_comb begin
        pc_en_s       = 1'b0;
        ifid_en_s     = 1'b0;
        idex_en_s     = 1'b0;
        exmem_en_s    = 1'b0;
        memwb_en_s    = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        memwb_flush_s = 1'b0;
        stall_evt_s   = 1'b0;
        flush_evt_s   = 1'b0;
        if (reset) begin
            pc_en_s = 1'b0;
        end else if (mem_stall_s) begin
            // WB gets a bubble so the frozen MEM instruction is not written twice
            memwb_en_s    = 1'b1;
            memwb_flush_s = 1'b1;
            stall_evt_s   = 1'b1;
        end else if (hz.ex_branch_taken) begin
            pc_en_s      = 1'b1;
            ifid_en_s    = 1'b1;
            idex_en_s    = 1'b1;
            exmem_en_s   = 1'b1;
            memwb_en_s   = 1'b1;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
            flush_evt_s  = 1'b1;
        end else if (load_use_s) begin
            idex_en_s    = 1'b1;
            exmem_en_s   = 1'b1;
            memwb_en_s   = 1'b1;
            idex_flush_s = 1'b1;
            stall_evt_s  = 1'b1;
        end else begin
            pc_en_s    = 1'b1;
            ifid_en_s  = 1'b1;
            idex_en_s  = 1'b1;
            exmem_en_s = 1'b1;
            memwb_en_s = 1'b1;
        end
    end

    // Operand forwarding selects, independent of stall state
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        if (reset) begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end else begin
            fwd_a_s = fwd_select(hz.ex_rs1, hz.mem_rd, hz.mem_reg_write,
                                 hz.wb_rd, hz.wb_reg_write);
            fwd_b_s = fwd_select(hz.ex_rs2, hz.mem_rd, hz.mem_reg_write,
                                 hz.wb_rd, hz.wb_reg_write);
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Saturating stall and flush performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r <= stall_evt_s ? sat_inc(stall_cnt_r) : stall_cnt_r;
            flush_cnt_r <= flush_evt_s ? sat_inc(flush_cnt_r) : flush_cnt_r;
        end
    end

    assign hz.pc_en           = pc_en_s;
    assign hz.ifid_en         = ifid_en_s;
    assign hz.idex_en         = idex_en_s;
    assign hz.exmem_en        = exmem_en_s;
    assign hz.memwb_en        = memwb_en_s;
    assign hz.ifid_flush      = ifid_flush_s;
    assign hz.idex_flush      = idex_flush_s;
    assign hz.memwb_flush     = memwb_flush_s;
    assign hz.fwd_a           = fwd_a_s;
    assign hz.fwd_b           = fwd_b_s;
    assign hz.mem_timeout_err = err_r;
    assign hz.stall_cnt       = stall_cnt_r;
    assign hz.flush_cnt       = flush_cnt_r;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage RV32I pipeline.
- Drives the enable and synchronous-flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable.
- Produces EX-stage operand-forwarding selects.
- Sequences data-memory wait states through a small FSM with a timeout, and keeps saturating stall and flush performance counters.

Parameters:
- MEM_TIMEOUT, 64: max consecutive dmem wait cycles before forced release (>=2).
- CNT_W, 16: width of performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  5 each  source regs of instruction in ID
- ex_rs1, ex_rs2  in  5 each  source regs of instruction in EX
- ex_rd  in  5  dest reg in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_rd  in  5  dest reg in EX/MEM
- mem_reg_write  in  1  EX/MEM writes register
- dmem_req  in  1  MEM stage access active
- dmem_ready  in  1  data memory completes access this cycle
- wb_rd  in  5  dest reg in MEM/WB
- wb_reg_write  in  1  MEM/WB writes register
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load zeros (bubble) on next edge
- fwd_a, fwd_b  out  2 each  00 regfile, 10 from EX/MEM, 01 from MEM/WB
- mem_timeout_err  out  1  sticky timeout flag
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters

Behaviour:
- Reset:
  - FSM to RUN; wait counter, stall_cnt and flush_cnt = 0; mem_timeout_err = 0.
  - While reset is high, all *_en = 0, all *_flush = 0, fwd_a = fwd_b = 00.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when dmem_req && !dmem_ready.
  - MEM_WAIT -> RUN when dmem_ready, or when the wait counter reaches MEM_TIMEOUT-1. The timeout case also sets mem_timeout_err, which stays set until reset.
  - The wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
- Memory stall: asserted when the FSM is in MEM_WAIT, or in RUN with dmem_req && !dmem_ready (combinational; zero-cycle detection).
  - pc_en = ifid_en = idex_en = exmem_en = 0.
  - memwb_en = 1 and memwb_flush = 1, so a bubble enters WB and no double writeback occurs.
  - All other flushes = 0.
  - On the release cycle (dmem_ready high, or the timeout cycle), the pipeline advances normally.
- Branch flush (no memory stall, ex_branch_taken = 1):
  - ifid_flush = idex_flush = 1; all enables = 1.
  - Takes priority over load-use.
  - If a branch and a memory stall coincide, the stall wins and the branch is re-evaluated when EX is released (EX is frozen, so the branch is not lost).
- Load-use (no memory stall, no branch): condition is ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2).
  - pc_en = ifid_en = 0; idex_flush = 1; idex_en = exmem_en = memwb_en = 1.
  - Exactly one bubble: on the next cycle the load has left EX, so the condition clears.
- Normal operation: all enables = 1, all flushes = 0.
- Forwarding (combinational, independent of stalls), for each of ex_rs1/fwd_a and ex_rs2/fwd_b:
  - 10 if mem_reg_write && mem_rd != 0 && mem_rd == rs;
  - else 01 if wb_reg_write && wb_rd != 0 && wb_rd == rs;
  - else 00.
  - The EX/MEM match has priority. x0 is never forwarded.
- Counters:
  - stall_cnt increments on each cycle with a memory stall or load-use stall.
  - flush_cnt increments on each cycle with branch flush asserted.
  - Both saturate at all-ones and never wrap.
- Reset mid-MEM_WAIT: immediate return to RUN; counters and error flag cleared.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Forward priority: mem_rd=wb_rd=ex_rs1=7, both reg_write=1 -> fwd_a=10. Clear mem_reg_write -> fwd_a=01. ex_rs1=0 with all rd=0 -> fwd_a=00.
- Branch vs load-use: ex_branch_taken=1 together with the load-use condition -> ifid_flush=idex_flush=1, pc_en=1, flush_cnt increments, stall_cnt unchanged.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high -> 3 cycles with pc_en/ifid_en/idex_en/exmem_en=0 and memwb_flush=1; release on cycle 4; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low -> forced release after 4 stalled cycles; mem_timeout_err=1 and stays 1 until reset.
- Reset mid-wait, plus saturation (CNT_W=4 with 20 stall cycles): reset returns state to RUN and zeros counters and err; stall_cnt stops at 15.
